rsfq_clocked_inv_array: RTL and testbench
=========================================

# rsfq_clocked_inv_array

Cycle-based, synthesizable emulation of an array of N clocked RSFQ inverter cells (clocked NOT), generalised with a selectable DRO mode, configurable output latency and per-channel timing-violation guards. SFQ pulses are modelled as single-cycle strobes on a fast host clock. The block sits in the emulation fabric wherever behavioural RSFQ cells are replaced by a clocked digital equivalent for FPGA prototyping and regression.

## Interface
Parameters:
- N_CH, 4: number of independent channels.
- MODE, 0: 0 = NOT (pulse out when clock finds cell empty); 1 = DRO (pulse out when clock finds cell armed).
- DELAY, 3: ck-to-q latency in host cycles, range 1..15.
- CT_CK_A, 2: cycles after an accepted ck during which an `a` pulse is a violation; 0 disables.
- CT_CK_CK, 3: cycles after an accepted ck during which a further ck is a violation; 0 disables.
- CT_A_CK, 2: cycles after a redundant `a` (cell already armed) during which ck is a violation; 0 disables.

Ports:
- clk  in  1  host clock; all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- a_p  in  N_CH  data pulse per channel, one-cycle strobe.
- ck_p  in  N_CH  cell clock pulse per channel, one-cycle strobe.
- err_clr  in  1  clears all sticky error bits.
- q_p  out  N_CH  output pulse per channel, one-cycle strobe.
- viol_p  out  N_CH  one-cycle strobe in the cycle a violation is detected.
- err  out  N_CH  sticky violation flag per channel.
- err_any  out  1  OR of err.

## Operation
- Per channel state: EMPTY or ARMED; plus guard counters g_a (guards `a`), g_ck (guards ck); plus DELAY-deep output shift line.
- Reset (rst_n=0 at edge): state EMPTY, counters 0, shift lines cleared, q_p=0, viol_p=0, err=0. Pulses in flight are discarded.
- ck_p, g_ck==0, accepted:
  - Output decision: MODE 0 -> emit if EMPTY; MODE 1 -> emit if ARMED.
  - Next state EMPTY in both modes.
  - If emitting: load g_a=CT_CK_A, g_ck=CT_CK_CK.
- ck_p with g_ck!=0: violation; ck dropped, state unchanged, no output scheduled.
- a_p, g_a==0: EMPTY -> ARMED; ARMED -> stays ARMED and loads g_ck=CT_A_CK.
- a_p with g_a!=0: violation; a dropped.
- Same-cycle a_p and ck_p: ck evaluated first against current state, counters loaded by it apply to the same-cycle `a` (so a+ck on EMPTY in MODE 0 emits and flags `a`). If ck does not load g_a, `a` is applied to the post-ck state (ARMED + a + ck in MODE 0 -> EMPTY then ARMED, no output).
- Guard counters decrement by 1 each cycle while nonzero; loaded values override decrement.
- Violation: viol_p[i]=1 that cycle, err[i] set. err_clr clears err the same edge; a violation in the same cycle as err_clr wins (err stays 1).
- Channels fully independent; err_any combinational OR of registered err.

## Timing
- Accepted emitting ck at cycle t -> q_p high exactly at cycle t+DELAY, one cycle wide.
- Back-to-back accepted emitting cks (guards disabled) produce back-to-back q_p pulses; shift line never drops pulses.
- Guard of value G covers cycles t..t+G-1 relative to loading edge t (inclusive of same cycle for a_p per ordering rule above); cycle t+G is legal.
- viol_p registered: asserted the cycle after the offending strobe is sampled; err updates on same edge.
- All outputs registered; no combinational input-to-output path except err_any from err.

## Structure
- Package rsfq_emu_pkg: cell state enum (EMPTY, ARMED), MODE constants (MODE_NOT, MODE_DRO), guard counter width function (clog2 of max CT + 1), DELAY_MAX=15.
- Sub-module rsfq_inv_chan: one channel (state, both guards, shift line, violation logic); top generates N_CH instances and builds err_any.

## Test plan
- MODE 0, defaults: ck_p[0] at cycle 10 on EMPTY -> q_p[0] at cycle 13; a_p[0] at 20, ck_p[0] at 30 -> no output, state EMPTY.
- MODE 1, DELAY=5: a_p[1] at 10, ck_p[1] at 20 -> q_p[1] at 25; ck_p[1] at 40 (EMPTY) -> no output.
- Guards: ck_p[2] at 10 then ck_p[2] at 12 -> viol_p[2] at 13, err[2]=1, single q_p at 13; ck at 13 instead -> accepted, q_p at 13 and 16.
- Simultaneous: MODE 0, a_p[3]+ck_p[3] at 10 on EMPTY -> q_p[3] at 13, viol_p[3] at 11; channel 3 stays EMPTY.
- Redundant arm: a_p[0] at 10 and 12, ck_p[0] at 13 -> violation, no output, remains ARMED; ck at 15 -> EMPTY, no output.
- Reset mid-flight: ck_p[0] at 10, rst_n low at 11 -> no q_p at 13; err_clr with concurrent violation -> err stays 1.

Source files
------------

// File: rtl/rsfq_emu_pkg.sv
// Shared types and constants for the clocked RSFQ inverter emulation.
package rsfq_emu_pkg;

  typedef enum logic {
    StEmpty,
    StArmed
  } cell_state_e;

  localparam int unsigned MODE_NOT  = 0;
  localparam int unsigned MODE_DRO  = 1;
  localparam int unsigned DELAY_MAX = 15;

  // Guard counters hold CT-1, so clog2(max CT + 1) bits are always enough.
  function automatic int unsigned guard_width(input int unsigned ct_a, input int unsigned ct_b,
                                              input int unsigned ct_c);
    int unsigned m;
    m = ct_a;
    if (ct_b > m) m = ct_b;
    if (ct_c > m) m = ct_c;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

  // Value to load so that a guard of G covers the loading cycle and the next G-1 cycles.
  function automatic int unsigned guard_load(input int unsigned ct);
    return (ct == 0) ? 0 : ct - 1;
  endfunction

endpackage

// File: rtl/rsfq_inv_chan.sv
// One clocked RSFQ inverter/DRO channel: cell state, timing guards and output delay line.
module rsfq_inv_chan
  import rsfq_emu_pkg::*;
#(
  parameter int unsigned MODE     = MODE_NOT,
  parameter int unsigned DELAY    = 3,
  parameter int unsigned CT_CK_A  = 2,
  parameter int unsigned CT_CK_CK = 3,
  parameter int unsigned CT_A_CK  = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic a_i,
  input  logic ck_i,
  input  logic err_clr_i,
  output logic q_o,
  output logic viol_o,
  output logic err_o
);

  localparam int unsigned GW = guard_width(CT_CK_A, CT_CK_CK, CT_A_CK);
  localparam logic [GW-1:0] LdCkA  = GW'(guard_load(CT_CK_A));
  localparam logic [GW-1:0] LdCkCk = GW'(guard_load(CT_CK_CK));
  localparam logic [GW-1:0] LdACk  = GW'(guard_load(CT_A_CK));

  cell_state_e      state_q, state_d, post_ck;
  logic [GW-1:0]    g_a_q, g_a_d, g_ck_q, g_ck_d;
  logic [DELAY-1:0] sr_q, sr_d;
  logic             viol_q, viol_d, err_q, err_d;
  logic             ck_ok, ck_bad, fire, a_blocked, a_ok, a_bad;

  // ck is resolved first; its guard loads already apply to a same-cycle `a`.
  always_comb begin
    ck_ok   = ck_i && (g_ck_q == '0);
    ck_bad  = ck_i && (g_ck_q != '0);
    fire    = ck_ok && ((MODE == MODE_DRO) ? (state_q == StArmed) : (state_q == StEmpty));
    post_ck = ck_ok ? StEmpty : state_q;

    a_blocked = (fire && (CT_CK_A != 0)) || (g_a_q != '0);
    a_ok      = a_i && !a_blocked;
    a_bad     = a_i && a_blocked;

    g_a_d  = (g_a_q == '0) ? '0 : g_a_q - 1'b1;
    g_ck_d = (g_ck_q == '0) ? '0 : g_ck_q - 1'b1;
    if (fire) begin
      g_a_d  = LdCkA;
      g_ck_d = LdCkCk;
    end

    state_d = post_ck;
    if (a_ok) begin
      if (post_ck == StEmpty) state_d = StArmed;
      else                    g_ck_d  = LdACk;  // redundant arm guards the next ck
    end

    sr_d   = DELAY'({sr_q, fire});
    viol_d = ck_bad || a_bad;
    err_d  = viol_d || (err_q && !err_clr_i);
  end

  // State registers with synchronous active-low reset; in-flight pulses are discarded.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      g_a_q   <= '0;
      g_ck_q  <= '0;
      sr_q    <= '0;
      viol_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      g_a_q   <= g_a_d;
      g_ck_q  <= g_ck_d;
      sr_q    <= sr_d;
      viol_q  <= viol_d;
      err_q   <= err_d;
    end
  end

  assign q_o    = sr_q[DELAY-1];
  assign viol_o = viol_q;
  assign err_o  = err_q;

endmodule

// File: rtl/rsfq_clocked_inv_array.sv
// Array of independent clocked RSFQ inverter channels with a combined error flag.
module rsfq_clocked_inv_array
  import rsfq_emu_pkg::*;
#(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned MODE     = MODE_NOT,
  parameter int unsigned DELAY    = 3,
  parameter int unsigned CT_CK_A  = 2,
  parameter int unsigned CT_CK_CK = 3,
  parameter int unsigned CT_A_CK  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] a_p,
  input  logic [N_CH-1:0] ck_p,
  input  logic            err_clr,
  output logic [N_CH-1:0] q_p,
  output logic [N_CH-1:0] viol_p,
  output logic [N_CH-1:0] err,
  output logic            err_any
);

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    rsfq_inv_chan #(
      .MODE    (MODE),
      .DELAY   (DELAY),
      .CT_CK_A (CT_CK_A),
      .CT_CK_CK(CT_CK_CK),
      .CT_A_CK (CT_A_CK)
    ) u_chan (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .a_i      (a_p[i]),
      .ck_i     (ck_p[i]),
      .err_clr_i(err_clr),
      .q_o      (q_p[i]),
      .viol_o   (viol_p[i]),
      .err_o    (err[i])
    );
  end

  // Only combinational output: reduction of the registered sticky flags.
  assign err_any = |err;

endmodule

// File: tb/tb_rsfq_clocked_inv_array.sv
// Directed bench: NOT-mode defaults, DRO with DELAY=5, and NOT with DELAY=1 and no guards.
module tb_rsfq_clocked_inv_array;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0] a0, ck0, q0, viol0, err0;
  logic [3:0] a1, ck1, q1, viol1, err1;
  logic [3:0] a2, ck2, q2, viol2, err2;
  logic       clr0, clr1, clr2, any0, any1, any2;

  int tests = 0;
  int fails = 0;

  rsfq_clocked_inv_array #(.N_CH(4), .MODE(0), .DELAY(3)) u0 (
    .clk(clk), .rst_n(rst_n), .a_p(a0), .ck_p(ck0), .err_clr(clr0),
    .q_p(q0), .viol_p(viol0), .err(err0), .err_any(any0)
  );

  rsfq_clocked_inv_array #(.N_CH(4), .MODE(1), .DELAY(5)) u1 (
    .clk(clk), .rst_n(rst_n), .a_p(a1), .ck_p(ck1), .err_clr(clr1),
    .q_p(q1), .viol_p(viol1), .err(err1), .err_any(any1)
  );

  rsfq_clocked_inv_array #(.N_CH(4), .MODE(0), .DELAY(1), .CT_CK_A(0), .CT_CK_CK(0),
                           .CT_A_CK(0)) u2 (
    .clk(clk), .rst_n(rst_n), .a_p(a2), .ck_p(ck2), .err_clr(clr2),
    .q_p(q2), .viol_p(viol2), .err(err2), .err_any(any2)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // After step(), outputs reflect the cycle following the sampled inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic p0(input logic [3:0] a, input logic [3:0] ck);
    a0 = a; ck0 = ck; step(); a0 = '0; ck0 = '0;
  endtask

  task automatic p1(input logic [3:0] a, input logic [3:0] ck);
    a1 = a; ck1 = ck; step(); a1 = '0; ck1 = '0;
  endtask

  task automatic p2(input logic [3:0] a, input logic [3:0] ck);
    a2 = a; ck2 = ck; step(); a2 = '0; ck2 = '0;
  endtask

  // Called right after the pulse step: checks q at t+1 .. t+d+1, pulse only at t+d.
  task automatic watch0(input string tag, input logic [3:0] mask, input int d);
    for (int k = 1; k <= d + 1; k++) begin
      chk(tag, q0, (k == d) ? mask : 4'b0000);
      step();
    end
  endtask

  task automatic watch1(input string tag, input logic [3:0] mask, input int d);
    for (int k = 1; k <= d + 1; k++) begin
      chk(tag, q1, (k == d) ? mask : 4'b0000);
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    a0 = '0; ck0 = '0; clr0 = 1'b0;
    a1 = '0; ck1 = '0; clr1 = 1'b0;
    a2 = '0; ck2 = '0; clr2 = 1'b0;
    idle(2);
    chk("rst_q0", q0, 4'b0000);
    chk("rst_viol0", viol0, 4'b0000);
    chk("rst_err0", err0, 4'b0000);
    chk("rst_any0", {3'b000, any0}, 4'b0000);
    chk("rst_q1", q1, 4'b0000);
    chk("rst_q2", q2, 4'b0000);
    rst_n = 1'b1;
    idle(3);

    // NOT mode: ck on empty cell emits after 3 cycles
    p0(4'b0000, 4'b0001);
    watch0("not_emit", 4'b0001, 3);
    idle(5);
    // a then ck: no output, cell returns to empty
    p0(4'b0001, 4'b0000);
    idle(9);
    p0(4'b0000, 4'b0001);
    watch0("not_armed_ck", 4'b0000, 3);
    idle(3);
    p0(4'b0000, 4'b0001);
    watch0("not_empty_again", 4'b0001, 3);
    idle(5);

    // DRO mode, DELAY=5
    p1(4'b0010, 4'b0000);
    idle(9);
    p1(4'b0000, 4'b0010);
    watch1("dro_emit", 4'b0010, 5);
    idle(10);
    p1(4'b0000, 4'b0010);
    watch1("dro_empty_ck", 4'b0000, 5);
    chk("dro_err", err1, 4'b0000);
    idle(5);

    // ck-ck guard violated at +2
    p0(4'b0000, 4'b0100);
    step();
    p0(4'b0000, 4'b0100);
    chk("ckck_viol", viol0, 4'b0100);
    chk("ckck_err", err0, 4'b0100);
    chk("ckck_any", {3'b000, any0}, 4'b0001);
    chk("ckck_q13", q0, 4'b0100);
    step();
    chk("ckck_viol_off", viol0, 4'b0000);
    chk("ckck_q14", q0, 4'b0000);
    idle(2);
    chk("ckck_q16", q0, 4'b0000);
    clr0 = 1'b1; step(); clr0 = 1'b0;
    chk("clr_err", err0, 4'b0000);
    chk("clr_any", {3'b000, any0}, 4'b0000);
    idle(5);

    // ck at +3 is legal
    p0(4'b0000, 4'b0100);
    idle(2);
    chk("ck3_q13", q0, 4'b0100);
    p0(4'b0000, 4'b0100);
    chk("ck3_viol", viol0, 4'b0000);
    chk("ck3_q14", q0, 4'b0000);
    step();
    chk("ck3_q15", q0, 4'b0000);
    step();
    chk("ck3_q16", q0, 4'b0100);
    chk("ck3_err", err0, 4'b0000);
    idle(5);

    // simultaneous a+ck on empty: emits, a flagged, stays empty
    p0(4'b1000, 4'b1000);
    chk("sim_viol", viol0, 4'b1000);
    chk("sim_q11", q0, 4'b0000);
    step();
    chk("sim_q12", q0, 4'b0000);
    step();
    chk("sim_q13", q0, 4'b1000);
    step();
    chk("sim_q14", q0, 4'b0000);
    idle(5);
    p0(4'b0000, 4'b1000);
    watch0("sim_still_empty", 4'b1000, 3);
    clr0 = 1'b1; step(); clr0 = 1'b0;
    chk("sim_clr", err0, 4'b0000);
    idle(5);

    // redundant arm guards the following ck
    p0(4'b0001, 4'b0000);
    step();
    p0(4'b0001, 4'b0000);
    chk("red_a_ok", viol0, 4'b0000);
    p0(4'b0000, 4'b0001);
    chk("red_ck_viol", viol0, 4'b0001);
    chk("red_ck_q", q0, 4'b0000);
    step();
    p0(4'b0000, 4'b0001);
    chk("red_ck15_viol", viol0, 4'b0000);
    watch0("red_armed_ck", 4'b0000, 3);
    idle(5);
    p0(4'b0000, 4'b0001);
    watch0("red_empty_after", 4'b0001, 3);
    idle(5);

    // reset discards in-flight pulse and clears sticky error
    chk("pre_rst_err", err0, 4'b0001);
    p0(4'b0000, 4'b0001);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_err", err0, 4'b0000);
    step();
    chk("midrst_q13", q0, 4'b0000);
    step();
    chk("midrst_q14", q0, 4'b0000);
    idle(5);

    // err_clr concurrent with a violation: violating channel keeps its flag
    p0(4'b0000, 4'b0110);
    p0(4'b0000, 4'b0100);
    chk("clrv_err_a", err0, 4'b0100);
    chk("clrv_viol_a", viol0, 4'b0100);
    clr0 = 1'b1;
    p0(4'b0000, 4'b0010);
    clr0 = 1'b0;
    chk("clrv_err_b", err0, 4'b0010);
    chk("clrv_viol_b", viol0, 4'b0010);
    chk("clrv_q", q0, 4'b0110);
    clr0 = 1'b1; step(); clr0 = 1'b0;
    chk("clrv_err_c", err0, 4'b0000);
    chk("clrv_any_c", {3'b000, any0}, 4'b0000);

    // no guards, DELAY=1: back-to-back emits, same-cycle a+ck arms
    p2(4'b0000, 4'b0001);
    chk("b2b_q1", q2, 4'b0001);
    p2(4'b0000, 4'b0001);
    chk("b2b_q2", q2, 4'b0001);
    p2(4'b0000, 4'b0001);
    chk("b2b_q3", q2, 4'b0001);
    step();
    chk("b2b_q4", q2, 4'b0000);
    p2(4'b0010, 4'b0010);
    chk("ng_sim_q", q2, 4'b0010);
    chk("ng_sim_viol", viol2, 4'b0000);
    p2(4'b0000, 4'b0010);
    chk("ng_armed_q", q2, 4'b0000);
    p2(4'b0000, 4'b0010);
    chk("ng_empty_q", q2, 4'b0010);
    step();
    chk("ng_err", err2, 4'b0000);
    chk("ng_any", {3'b000, any2}, 4'b0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
